pattern_merge_scheduler: RTL

Shares one pattern-merged sequential netlist instance (the DUT: 11 inputs, 11 outputs, flop-based) among NUM_REQ requesters. Round-robin arbitration picks one requester's input vector. The vector is held on the DUT inputs for SETTLE clock edges so the registered logic propagates, then the DUT outputs are captured and returned with the requester id. Sits between stimulus sources and the merged netlist in the graph-grammar evaluation harness.

---
 rtl/pattern_merge_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pattern_merge_scheduler.sv
// ---------------------------------------------------------------------------
// pattern_merge_scheduler
//
// Time-shares one flop-based pattern-merged netlist among NUM_REQ stimulus
// sources. A round-robin arbiter picks one requester's input vector. The
// vector is driven onto the netlist inputs and held for SETTLE clock edges so
// the registered logic can propagate. The netlist outputs are then captured
// and returned together with the requester index.
//
// Ports:
//   blif_clk_net    in   1               clock, rising edge
//   blif_reset_net  in   1               asynchronous reset, active-high
//   req_valid       in   NUM_REQ         per-requester request valid
//   req_data        in   NUM_REQ*IN_W    slice i = bits [i*IN_W +: IN_W]
//   req_ready       out  NUM_REQ         one-hot, one-cycle accept pulse
//   dut_in          out  IN_W            vector driven to the netlist
//   dut_out         in   OUT_W           netlist outputs
//   dut_busy        out  1               vector being applied (DRIVE/SETTLE)
//   resp_valid      out  1               response valid
//   resp_id         out  $clog2(NUM_REQ) requester index of the response
//   resp_data       out  OUT_W           captured dut_out
//   resp_ready      in   1               downstream accepts the response
//
// Optional feature (macro PATTERN_SCHED_PARITY_EN):
//   resp_parity     out  1               XOR of captured dut_out
//   parity_err      out  1               sticky: dut_out parity changed in RESP
// ---------------------------------------------------------------------------
module pattern_merge_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 11,
    parameter int OUT_W   = 11,
    parameter int SETTLE  = 3
) (
    input  logic                       blif_clk_net,
    input  logic                       blif_reset_net,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*IN_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [IN_W-1:0]            dut_in,
    input  logic [OUT_W-1:0]           dut_out,
    output logic                       dut_busy,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [OUT_W-1:0]           resp_data,
`ifdef PATTERN_SCHED_PARITY_EN
    output logic                       resp_parity,
    output logic                       parity_err,
`endif
    input  logic                       resp_ready
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    state_t            state, next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  settle_cnt;
    logic [ID_W-1:0]   grant;
    logic              grant_vld;

    // Round-robin pick: scan from the highest offset down so the requester
    // closest to rr_ptr (offset 0) is the last, and therefore winning, write.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                grant     = ID_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) state <= ST_IDLE;
        else                state <= next_state;
    end

    always_comb begin
        next_state = state;
        dut_busy   = 1'b0;
        case (state)
            ST_IDLE:    if (grant_vld) next_state = ST_DRIVE;
            ST_DRIVE: begin
                dut_busy   = 1'b1;
                next_state = (SETTLE == 1) ? ST_CAPTURE : ST_SETTLE;
            end
            ST_SETTLE: begin
                dut_busy = 1'b1;
                if (settle_cnt == '0) next_state = ST_CAPTURE;
            end
            ST_CAPTURE: next_state = ST_RESP;
            ST_RESP:    if (resp_ready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            rr_ptr      <= '0;
            req_ready   <= '0;
            dut_in      <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_data   <= '0;
            settle_cnt  <= '0;
`ifdef PATTERN_SCHED_PARITY_EN
            resp_parity <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            // Accept pulse lasts exactly one cycle.
            req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        dut_in    <= req_data[int'(grant)*IN_W +: IN_W];
                        req_ready <= NUM_REQ'(1) << grant;
                        resp_id   <= grant;
                        rr_ptr    <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
                    end
                end
                ST_DRIVE:   settle_cnt <= CNT_W'(SETTLE - 1);
                ST_SETTLE:  if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_W'(1);
                ST_CAPTURE: begin
                    resp_data   <= dut_out;
                    resp_valid  <= 1'b1;
`ifdef PATTERN_SCHED_PARITY_EN
                    resp_parity <= ^dut_out;
`endif
                end
                ST_RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
`ifdef PATTERN_SCHED_PARITY_EN
                    // A parity change after capture means the netlist had not
                    // settled when it was sampled.
                    if ((^dut_out) != resp_parity) parity_err <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
